// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache slice.
//   ADDR_TYPE / INST_TYPE : byte address and instruction word types
//   INST_CNT_NUM          : instructions per cache line (MemoryControl burst length)
//   TRUE / FALSE          : single-bit constants
//   INST_RESET            : value instruction registers take on reset
//   cache_state_t         : controller states
package inst_cache_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam int INST_CNT_NUM = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam INST_TYPE INST_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    ABORT  = 2'd3
  } cache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid / tag / data storage for the direct-mapped instruction cache.
//   clk_in, rst_in                  : clock, synchronous active-high reset (clears valid bits only)
//   rd_index, rd_word               : combinational read port
//   rd_valid, rd_tag, rd_data       : contents of the addressed line / word
//   wr_index, wr_word, wr_data      : write address and instruction word
//   data_we                         : write wr_data into (wr_index, wr_word)
//   tag_we, wr_tag                  : write the line tag
//   valid_we, wr_valid              : set or clear the line valid bit
module icache_line_array
  import inst_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = INST_CNT_NUM,
  parameter int TAG_W          = 24,
  parameter int IDX_W          = $clog2(LINES),
  parameter int OFF_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             data_we,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             valid_we,
  input  logic             wr_valid
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  INST_TYPE         data_mem [LINES*WORDS_PER_LINE];

  // Only the valid bits need resetting; tags and data are qualified by them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (valid_we) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
    if (data_we) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the fetcher and MemoryControl's fetcher port.
//   clk_in, rst_in, rdy_in     : clock, synchronous active-high reset, global freeze (0 = hold)
//   pc_valid_in, pc_in         : fetch request, held by the fetcher until inst_valid_out
//   flush_in                   : abandon the current request or line fill
//   inst_valid_out, inst_out   : one-cycle response pulse with the instruction
//   mc_enable_out, mc_address_out, mc_reset_out : line-fill request / abort to MemoryControl
//   mc_one_inst_in, mc_inst_in : one delivered burst word
//   mc_end_in                  : MemoryControl ended the burst
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = INST_CNT_NUM,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              pc_valid_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush_in,
  output logic              inst_valid_out,
  output logic [31:0]       inst_out,
  output logic              mc_enable_out,
  output logic [ADDR_W-1:0] mc_address_out,
  output logic              mc_reset_out,
  input  logic              mc_one_inst_in,
  input  logic [31:0]       mc_inst_in,
  input  logic              mc_end_in
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - OFF - 2;
  localparam logic [OFF:0] LAST_WORD = (OFF+1)'(WORDS_PER_LINE - 1);

  cache_state_t state, next_state;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OFF:0]      fill_cnt, fill_cnt_d;
  logic              inst_valid_d, mc_enable_d, mc_reset_d;
  INST_TYPE          inst_d;
  logic [ADDR_W-1:0] mc_address_d;
  logic              data_we, tag_we, valid_we, wr_valid;

  logic [IDX-1:0]    index_sel;
  logic [OFF-1:0]    word_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic [ADDR_W-1:0] line_base;
  logic              rd_valid, hit, accept, last_word;
  logic [TAG_W-1:0]  rd_tag;
  INST_TYPE          rd_data;
  logic              unused_pc_bits;

  assign word_sel       = pc_q[OFF+1:2];
  assign index_sel      = pc_q[IDX+OFF+1:OFF+2];
  assign tag_sel        = pc_q[ADDR_W-1:IDX+OFF+2];
  assign line_base      = {pc_q[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
  assign unused_pc_bits = ^pc_q[1:0];

  assign hit = rd_valid && (rd_tag == tag_sel);
  // The fetcher still shows the answered request during the response cycle,
  // so a new request is only taken once inst_valid_out has dropped.
  assign accept    = pc_valid_in && !flush_in && !inst_valid_out;
  assign last_word = mc_one_inst_in && (fill_cnt == LAST_WORD);

  icache_line_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_lines (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (index_sel),
    .rd_word  (word_sel),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_index (index_sel),
    .wr_word  (fill_cnt[OFF-1:0]),
    .wr_data  (mc_inst_in),
    .data_we  (data_we && rdy_in),
    .tag_we   (tag_we && rdy_in),
    .wr_tag   (tag_sel),
    .valid_we (valid_we && rdy_in),
    .wr_valid (wr_valid)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= next_state;
    end
  end

  // Flush has priority everywhere; a completing word beats a simultaneous mc_end_in.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept) next_state = LOOKUP;
      LOOKUP: if (flush_in || hit) next_state = IDLE;
              else next_state = FILL;
      FILL:   if (flush_in) next_state = ABORT;
              else if (last_word || mc_end_in) next_state = IDLE;
      ABORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values for the registered outputs and the array write strobes.
  always_comb begin
    pc_d         = pc_q;
    fill_cnt_d   = fill_cnt;
    inst_valid_d = FALSE;
    inst_d       = inst_out;
    mc_enable_d  = mc_enable_out;
    mc_address_d = mc_address_out;
    mc_reset_d   = FALSE;
    data_we      = FALSE;
    tag_we       = FALSE;
    valid_we     = FALSE;
    wr_valid     = FALSE;
    case (state)
      IDLE: begin
        if (accept) pc_d = pc_in;
      end
      LOOKUP: begin
        if (!flush_in) begin
          if (hit) begin
            inst_valid_d = TRUE;
            inst_d       = rd_data;
          end else begin
            valid_we     = TRUE;
            mc_enable_d  = TRUE;
            mc_address_d = line_base;
            fill_cnt_d   = '0;
          end
        end
      end
      FILL: begin
        if (flush_in) begin
          mc_enable_d  = FALSE;
          mc_address_d = '0;
          mc_reset_d   = TRUE;
        end else if (mc_one_inst_in) begin
          data_we    = TRUE;
          fill_cnt_d = fill_cnt + (OFF+1)'(1);
          if (last_word) begin
            tag_we       = TRUE;
            valid_we     = TRUE;
            wr_valid     = TRUE;
            mc_enable_d  = FALSE;
            mc_address_d = '0;
          end
        end else if (mc_end_in) begin
          mc_enable_d  = FALSE;
          mc_address_d = '0;
        end
      end
      ABORT: begin
        mc_enable_d  = FALSE;
        mc_address_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q           <= '0;
      fill_cnt       <= '0;
      inst_valid_out <= FALSE;
      inst_out       <= INST_RESET;
      mc_enable_out  <= FALSE;
      mc_address_out <= '0;
      mc_reset_out   <= FALSE;
    end else if (rdy_in) begin
      pc_q           <= pc_d;
      fill_cnt       <= fill_cnt_d;
      inst_valid_out <= inst_valid_d;
      inst_out       <= inst_d;
      mc_enable_out  <= mc_enable_d;
      mc_address_out <= mc_address_d;
      mc_reset_out   <= mc_reset_d;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache (default 16 lines x 4 words).
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, pc_valid_in, flush_in;
  logic [31:0] pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        mc_enable_out;
  logic [31:0] mc_address_out;
  logic        mc_reset_out;
  logic        mc_one_inst_in;
  logic [31:0] mc_inst_in;
  logic        mc_end_in;

  int checks = 0;
  int errors = 0;

  inst_cache dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .pc_valid_in    (pc_valid_in),
    .pc_in          (pc_in),
    .flush_in       (flush_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .mc_enable_out  (mc_enable_out),
    .mc_address_out (mc_address_out),
    .mc_reset_out   (mc_reset_out),
    .mc_one_inst_in (mc_one_inst_in),
    .mc_inst_in     (mc_inst_in),
    .mc_end_in      (mc_end_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One fetch: request, and for a miss serve a 4-word burst starting at fill_base.
  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic expect_miss,
                               input logic [31:0] fill_base, input logic [31:0] exp_inst);
    pc_in = pc;
    pc_valid_in = 1'b1;
    tick();
    checkOutput({tag, "_lookup_valid"}, {31'd0, inst_valid_out}, 32'd0);
    tick();
    if (expect_miss) begin
      checkOutput({tag, "_mc_en"}, {31'd0, mc_enable_out}, 32'd1);
      checkOutput({tag, "_mc_addr"}, mc_address_out, pc & 32'hFFFF_FFF0);
      for (int k = 0; k < 4; k++) begin
        mc_one_inst_in = 1'b1;
        mc_inst_in = fill_base + k;
        tick();
      end
      mc_one_inst_in = 1'b0;
      checkOutput({tag, "_mc_en_drop"}, {31'd0, mc_enable_out}, 32'd0);
      tick();
      tick();
    end else begin
      checkOutput({tag, "_hit_no_mc"}, {31'd0, mc_enable_out}, 32'd0);
    end
    checkOutput({tag, "_valid"}, {31'd0, inst_valid_out}, 32'd1);
    checkOutput({tag, "_inst"}, inst_out, exp_inst);
    pc_valid_in = 1'b0;
    tick();
    checkOutput({tag, "_pulse_end"}, {31'd0, inst_valid_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; pc_valid_in = 1'b0; pc_in = '0; flush_in = 1'b0;
    mc_one_inst_in = 1'b0; mc_inst_in = '0; mc_end_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    checkOutput("rst_valid", {31'd0, inst_valid_out}, 32'd0);
    checkOutput("rst_inst", inst_out, 32'd0);
    checkOutput("rst_mc_en", {31'd0, mc_enable_out}, 32'd0);
    checkOutput("rst_mc_addr", mc_address_out, 32'd0);
    checkOutput("rst_mc_reset", {31'd0, mc_reset_out}, 32'd0);

    $display("[TB] cold miss and hit");
    applyStimulus("cold", 32'h0000_0010, 1'b1, 32'h0000_00A0, 32'h0000_00A0);
    applyStimulus("hit14", 32'h0000_0014, 1'b0, 32'h0, 32'h0000_00A1);

    $display("[TB] conflict eviction");
    applyStimulus("evict110", 32'h0000_0110, 1'b1, 32'h0000_00B0, 32'h0000_00B0);
    applyStimulus("hit11c", 32'h0000_011C, 1'b0, 32'h0, 32'h0000_00B3);
    applyStimulus("remiss10", 32'h0000_0010, 1'b1, 32'h0000_00A0, 32'h0000_00A0);
    applyStimulus("hit18", 32'h0000_0018, 1'b0, 32'h0, 32'h0000_00A2);

    $display("[TB] flush after two words");
    pc_in = 32'h0000_0024; pc_valid_in = 1'b1;
    tick();
    tick();
    checkOutput("flush_mc_en", {31'd0, mc_enable_out}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      mc_one_inst_in = 1'b1; mc_inst_in = 32'hC0 + k;
      tick();
    end
    mc_one_inst_in = 1'b0;
    flush_in = 1'b1; pc_valid_in = 1'b0;
    tick();
    flush_in = 1'b0;
    checkOutput("flush_mc_reset", {31'd0, mc_reset_out}, 32'd1);
    checkOutput("flush_mc_en0", {31'd0, mc_enable_out}, 32'd0);
    tick();
    checkOutput("abort_mc_reset", {31'd0, mc_reset_out}, 32'd0);
    checkOutput("abort_mc_addr", mc_address_out, 32'd0);
    applyStimulus("refetch24", 32'h0000_0024, 1'b1, 32'h0000_00C0, 32'h0000_00C1);

    $display("[TB] flush with last word");
    pc_in = 32'h0000_0030; pc_valid_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      mc_one_inst_in = 1'b1; mc_inst_in = 32'hD0 + k;
      tick();
    end
    mc_inst_in = 32'hD3; flush_in = 1'b1; pc_valid_in = 1'b0;
    tick();
    mc_one_inst_in = 1'b0; flush_in = 1'b0;
    checkOutput("flushlast_mc_reset", {31'd0, mc_reset_out}, 32'd1);
    tick();
    applyStimulus("flushlast_miss", 32'h0000_0030, 1'b1, 32'h0000_00D0, 32'h0000_00D0);

    $display("[TB] early mc_end");
    pc_in = 32'h0000_0040; pc_valid_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      mc_one_inst_in = 1'b1; mc_inst_in = 32'hE0 + k;
      tick();
    end
    mc_one_inst_in = 1'b0; mc_end_in = 1'b1; pc_valid_in = 1'b0;
    tick();
    mc_end_in = 1'b0;
    checkOutput("end_mc_en0", {31'd0, mc_enable_out}, 32'd0);
    checkOutput("end_mc_reset", {31'd0, mc_reset_out}, 32'd0);
    applyStimulus("end_miss", 32'h0000_0044, 1'b1, 32'h0000_00E0, 32'h0000_00E1);

    $display("[TB] rdy low mid fill");
    pc_in = 32'h0000_0050; pc_valid_in = 1'b1;
    tick();
    tick();
    mc_one_inst_in = 1'b1; mc_inst_in = 32'hF0;
    tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mc_inst_in = 32'hDEAD_0000 + k;
      tick();
      checkOutput("frozen_mc_en", {31'd0, mc_enable_out}, 32'd1);
    end
    rdy_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      mc_inst_in = 32'hF0 + k;
      if (k < 3) begin
        tick();
        checkOutput("resume_mc_en", {31'd0, mc_enable_out}, 32'd1);
      end else begin
        tick();
      end
    end
    mc_one_inst_in = 1'b0;
    checkOutput("resume_done_en", {31'd0, mc_enable_out}, 32'd0);
    tick();
    tick();
    checkOutput("resume_valid", {31'd0, inst_valid_out}, 32'd1);
    checkOutput("resume_inst", inst_out, 32'h0000_00F0);
    pc_valid_in = 1'b0;
    tick();
    applyStimulus("frozen_hit54", 32'h0000_0054, 1'b0, 32'h0, 32'h0000_00F1);
    applyStimulus("frozen_hit5c", 32'h0000_005C, 1'b0, 32'h0, 32'h0000_00F3);

    $display("[TB] reset mid fill");
    pc_in = 32'h0000_0060; pc_valid_in = 1'b1;
    tick();
    tick();
    mc_one_inst_in = 1'b1; mc_inst_in = 32'h60;
    tick();
    mc_one_inst_in = 1'b0; rst_in = 1'b1; pc_valid_in = 1'b0;
    tick();
    rst_in = 1'b0;
    checkOutput("midrst_mc_en", {31'd0, mc_enable_out}, 32'd0);
    checkOutput("midrst_mc_addr", mc_address_out, 32'd0);
    checkOutput("midrst_mc_reset", {31'd0, mc_reset_out}, 32'd0);
    checkOutput("midrst_valid", {31'd0, inst_valid_out}, 32'd0);
    checkOutput("midrst_inst", inst_out, 32'd0);
    applyStimulus("postrst14", 32'h0000_0014, 1'b1, 32'h0000_00A8, 32'h0000_00A9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
